// File: rtl/led_arb_pkg.sv
// Shared types, widths and pattern helpers for the LED arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    LOCAL  = 2'd0,
    HPS    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PASS  = 2'b00,
    WALK  = 2'b01,
    COUNT = 2'b10,
    BLINK = 2'b11
  } mode_t;

  localparam logic [LED_W-1:0] WALK_SEED  = LED_W'(8'h01);
  localparam logic [LED_W-1:0] COUNT_SEED = LED_W'(8'h00);
  localparam logic [LED_W-1:0] BLINK_SEED = LED_W'(8'h00);

  // Pattern loaded when the mode changes; PASS simply mirrors the switches.
  function automatic logic [LED_W-1:0] mode_seed(input mode_t mode,
                                                 input logic [LED_W-1:0] sw);
    logic [LED_W-1:0] seed;
    seed = sw;
    case (mode)
      PASS:    seed = sw;
      WALK:    seed = WALK_SEED;
      COUNT:   seed = COUNT_SEED;
      BLINK:   seed = BLINK_SEED;
      default: seed = sw;
    endcase
    return seed;
  endfunction

  // Pattern after one step tick in the given mode.
  function automatic logic [LED_W-1:0] step_pattern(input mode_t mode,
                                                    input logic [LED_W-1:0] pat,
                                                    input logic [LED_W-1:0] sw);
    logic [LED_W-1:0] nxt;
    nxt = pat;
    case (mode)
      PASS:    nxt = sw;
      WALK:    nxt = {pat[LED_W-2:0], pat[LED_W-1]};
      COUNT:   nxt = pat + LED_W'(1);
      BLINK:   nxt = ~pat;
      default: nxt = pat;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_arbiter_switch_debounce.sv
// Two-flop synchroniser followed by a stability counter for a switch vector.
module switch_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    count;

  // Any change restarts the window; the value is accepted as the count reaches its end.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      candidate <= '0;
      count     <= '0;
      stable    <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 != candidate) begin
        candidate <= sync_q2;
        count     <= '0;
      end else if (count != CW'(DEBOUNCE_CYCLES - 1)) begin
        count <= count + CW'(1);
        if (count == CW'(DEBOUNCE_CYCLES - 2)) begin
          stable <= candidate;
        end
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Arbitrates the board LEDs between the HPS PIO word and a switch-driven pattern sequencer.
// Optional LED_ARB_STATUS_EN adds a saturating handover_count output.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STEP_CYCLES     = 12500000,
  parameter int unsigned HOLD_CYCLES     = 100000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [LED_W-1:0] switches_in,
  input  logic [LED_W-1:0] hps_leds,
  input  logic             hps_wr,
  output logic [LED_W-1:0] leds_out,
  output logic             hps_owner,
  output logic [LED_W-1:0] sw_stable
`ifdef LED_ARB_STATUS_EN
  ,
  output logic [7:0]       handover_count
`endif
);

  localparam int unsigned SW = $clog2(STEP_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  state_t           state;
  state_t           next_state;
  mode_t            mode_c;
  mode_t            mode_prev;
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] hps_word;
  logic [SW-1:0]    step;
  logic [HW-1:0]    hold;
  logic             latch_c;
  logic             hold_dec_c;
  logic             tick_c;
  logic             mode_change_c;
  logic [LED_W-1:0] led_next_c;

  switch_debounce #(
    .WIDTH           (LED_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk_clk),
    .reset  (reset_reset),
    .raw    (switches_in),
    .stable (sw_stable)
  );

  assign mode_c        = mode_t'(sw_stable[1:0]);
  assign mode_change_c = (mode_c != mode_prev);
  assign tick_c        = (state != HPS) && (step == SW'(STEP_CYCLES - 1));

  // Grant FSM: lock dominates, HPS writes grab or extend the grant, hold expiry releases it.
  always_comb begin
    next_state = state;
    latch_c    = 1'b0;
    hold_dec_c = 1'b0;
    case (state)
      LOCAL: begin
        if (sw_stable[7]) begin
          next_state = LOCKED;
        end else if (hps_wr) begin
          next_state = HPS;
          latch_c    = 1'b1;
        end
      end
      HPS: begin
        if (sw_stable[7]) begin
          next_state = LOCKED;
        end else if (hps_wr) begin
          latch_c = 1'b1;
        end else if (hold == '0) begin
          next_state = LOCAL;
        end else begin
          hold_dec_c = 1'b1;
        end
      end
      LOCKED: begin
        if (!sw_stable[7]) begin
          next_state = LOCAL;
        end
      end
      default: next_state = LOCAL;
    endcase
    led_next_c = (next_state == HPS) ? (latch_c ? hps_leds : hps_word) : pattern;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= LOCAL;
    end else begin
      state <= next_state;
    end
  end

  // Pattern sequencer; a mode change reseeds and restarts the step period ahead of any tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mode_prev <= PASS;
      pattern   <= WALK_SEED;
      step      <= '0;
    end else begin
      mode_prev <= mode_c;
      if (mode_change_c) begin
        pattern <= mode_seed(mode_c, sw_stable);
        step    <= '0;
      end else begin
        if (mode_c == PASS) begin
          pattern <= sw_stable;
        end else if (tick_c) begin
          pattern <= step_pattern(mode_c, pattern, sw_stable);
        end
        if (state != HPS) begin
          step <= tick_c ? '0 : step + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold      <= '0;
      hps_word  <= '0;
      leds_out  <= '0;
      hps_owner <= 1'b0;
    end else begin
      if (latch_c) begin
        hold     <= HW'(HOLD_CYCLES - 1);
        hps_word <= hps_leds;
      end else if (hold_dec_c) begin
        hold <= hold - HW'(1);
      end
      leds_out  <= led_next_c;
      hps_owner <= (next_state == HPS);
    end
  end

`ifdef LED_ARB_STATUS_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      handover_count <= '0;
    end else if ((state == LOCAL) && (next_state == HPS) && (handover_count != 8'hFF)) begin
      handover_count <= handover_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the 8 board LEDs between two requesters: the HPS LED PIO word and a local, switch-driven pattern sequencer.
- Debounces the 8 slide switches and selects the local pattern mode from them.
- Grants the LEDs to the HPS on each HPS write, holds that grant for a timeout, then hands the LEDs back to the local sequencer.
- Sits in the FPGA top level between the HPS system's leds_export/switches_export and the board pins.

Parameters:
- DEBOUNCE_CYCLES, 50000: cycles the synchronised switch vector must stay constant before it is accepted (≥2).
- STEP_CYCLES, 12500000: local pattern step period in clocks (≥2).
- HOLD_CYCLES, 100000000: HPS grant timeout after the last HPS write (≥2).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- switches_in  in  8  raw board switches, asynchronous
- hps_leds  in  8  LED word from the HPS PIO
- hps_wr  in  1  single-cycle strobe; hps_leds valid when high
- leds_out  out  8  registered LED drive
- hps_owner  out  1  registered; 1 while the HPS holds the grant
- sw_stable  out  8  debounced switch vector, forwarded to switches_export

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: leds_out=0, hps_owner=0, sw_stable=0, state=LOCAL, pattern=8'h01, step/hold/debounce counters=0, latched HPS word=0.
- Debounce:
  - 2-flop synchroniser, then compare against a candidate register.
  - Any change reloads the candidate and clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1, sw_stable<=candidate.
  - Net latency from a raw change to sw_stable: DEBOUNCE_CYCLES+2 clocks. A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Mode = sw_stable[1:0]; lock = sw_stable[7].
- Step tick: the step counter runs 0..STEP_CYCLES-1 in LOCAL/LOCKED; tick = wrap. The counter is frozen in HPS.
- Pattern per tick:
  - 00: pattern=sw_stable; no tick dependency.
  - 01: rotate left by 1; 8'h80 wraps to 8'h01.
  - 10: increment mod 256; 8'hFF wraps to 8'h00.
  - 11: invert (8'h00/8'hFF blink).
- Mode change (sw_stable[1:0] differs from the previous cycle): pattern reloads its seed (01→8'h01, 10→8'h00, 11→8'h00) and the step counter clears. This takes priority over a tick in the same cycle.
- FSM:
  - LOCAL:
    - lock → LOCKED.
    - else hps_wr → HPS: latch hps_leds, hold<=HOLD_CYCLES-1.
  - HPS:
    - lock → LOCKED; this beats hps_wr in the same cycle.
    - else hps_wr: relatch hps_leds, reload hold (grant extended).
    - else hold==0 → LOCAL.
    - else hold decrements.
  - LOCKED:
    - hps_wr ignored, no latch.
    - !lock → LOCAL.
- Output: leds_out <= (next_state==HPS) ? latched/incoming HPS word : pattern. Latency is 1 clock from hps_wr to leds_out showing hps_leds. hps_owner <= (next_state==HPS).
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: LED_ARB_STATUS_EN.
- Defined:
  - Adds output port handover_count [7:0].
  - Saturating count of LOCAL→HPS transitions; sticks at 8'hFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package led_arb_pkg holds:
  - state enum {LOCAL, HPS, LOCKED};
  - mode enum {PASS, WALK, COUNT, BLINK};
  - seed constants WALK_SEED=8'h01, COUNT_SEED=8'h00, BLINK_SEED=8'h00;
  - LED_W=8.
- Sub-module switch_debounce, parameterised by width and DEBOUNCE_CYCLES: synchroniser plus debounce counter.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, STEP_CYCLES=3, HOLD_CYCLES=10.
- Reset, then switches_in=8'h01 constant → sw_stable=8'h01 exactly 6 clocks later. leds_out walks 01→02→04 every 3 clocks, and 80→01 on wrap.
- Switch glitch 8'h02 for 3 clocks, then back → sw_stable unchanged.
- In LOCAL, hps_wr with hps_leds=8'hA5 → next clock leds_out=A5, hps_owner=1. With no further write, exactly 11 clocks after the strobe hps_owner=0 and leds_out=pattern. Pattern resumes from its frozen value.
- Second hps_wr (8'h3C) at hold=2 → leds_out=3C and the grant is extended by a full 10-clock window.
- sw_stable[7]=1 in the same cycle as hps_wr → state LOCKED, leds_out stays the pattern, hps_owner=0. Later writes are ignored until sw[7]=0.
- Mode 10 running from 8'hFE, 2 ticks → FF then 00. Mid-count switch to mode 11 → pattern=00, then FF after 3 clocks. With LED_ARB_STATUS_EN, 300 HPS handovers → handover_count=8'hFF.
